// File: rtl/mio_bus_responder.sv
// mio_bus_responder: memory/IO bus responder with RAM, LEDs, switches and wait states.
// Optional free-running counter at 0xF000_0004 when MIO_COUNTER_EN is defined.
module mio_bus_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int RAM_WORDS   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CPU_MIO,
    input  logic        mem_ifWriteMem,
    input  logic [31:0] Address_out,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    input  logic [15:0] switches,
    output logic [15:0] leds,
    output logic        bus_error
);
    localparam int AW = $clog2(RAM_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:2] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic [15:0] leds_q, leds_d;
    logic        err_q, err_d;
    logic [31:0] mem [RAM_WORDS];
    logic        capture, resp, is_ram, is_led, is_sw, mapped;
    logic [31:0] rdata;
    logic        unused;
`ifdef MIO_COUNTER_EN
    logic [31:0] ctr_q, ctr_d;
    logic        is_ctr;
`endif

    assign unused = ^Address_out[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            leds_q  <= '0;
            err_q   <= 1'b0;
`ifdef MIO_COUNTER_EN
            ctr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            leds_q  <= leds_d;
            err_q   <= err_d;
`ifdef MIO_COUNTER_EN
            ctr_q   <= ctr_d;
`endif
        end
    end

    // RAM is deliberately left out of reset; writes only happen in RESP
    always_ff @(posedge clk)
        if (resp && we_q && is_ram) mem[addr_q[AW+1:2]] <= wdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = CPU_MIO ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE;
            WAIT:    state_d = cnt_q <= 4'd1 ? RESP : WAIT;
            RESP:    state_d = DONE;
            default: state_d = CPU_MIO ? DONE : IDLE;
        endcase
    end

    always_comb begin
        capture = state_q == IDLE && CPU_MIO;
        resp    = state_q == RESP;
        is_ram  = addr_q[31:AW+2] == '0;
        is_led  = addr_q == 30'h3800_0000;
        is_sw   = addr_q == 30'h3C00_0000;
        mapped  = is_ram | is_led | is_sw;
        rdata   = is_ram ? mem[addr_q[AW+1:2]] :
                  is_led ? {16'b0, leds_q} :
                  is_sw  ? {16'b0, switches} : 32'b0;
`ifdef MIO_COUNTER_EN
        is_ctr  = addr_q == 30'h3C00_0001;
        mapped  = mapped | is_ctr;
        rdata   = is_ctr ? ctr_q : rdata;
        ctr_d   = resp && we_q && is_ctr ? wdata_q : ctr_q + 32'd1;
`endif
        addr_d  = capture ? Address_out[31:2] : addr_q;
        wdata_d = capture ? Data_out : wdata_q;
        we_d    = capture ? mem_ifWriteMem : we_q;
        cnt_d   = capture ? 4'(WAIT_CYCLES) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
        leds_d  = resp && we_q && is_led ? wdata_q[15:0] : leds_q;
        err_d   = err_q | (resp && !mapped);
        Data_in = resp && !we_q ? rdata : rdata_q;
        rdata_d = Data_in;
        MIO_ready = resp;
        leds      = leds_q;
        bus_error = err_q;
    end
endmodule

// File: tb/tb_mio_bus_responder.sv
// tb_mio_bus_responder: directed checks on two responders (WAIT_CYCLES=2 and 0).
module tb_mio_bus_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu0, cpu2, we;
    logic [31:0] addr, wdata;
    logic [15:0] sw;
    logic [31:0] din0, din2;
    logic        rdy0, rdy2, err0, err2;
    logic [15:0] leds0, leds2;
    int          errors = 0;
    int          checks = 0;
    int          pulses;

    always #5 clk = ~clk;

    mio_bus_responder #(.WAIT_CYCLES(2), .RAM_WORDS(64)) u2 (
        .clk(clk), .rst(rst), .CPU_MIO(cpu2), .mem_ifWriteMem(we),
        .Address_out(addr), .Data_out(wdata), .Data_in(din2), .MIO_ready(rdy2),
        .switches(sw), .leds(leds2), .bus_error(err2)
    );

    mio_bus_responder #(.WAIT_CYCLES(0), .RAM_WORDS(64)) u0 (
        .clk(clk), .rst(rst), .CPU_MIO(cpu0), .mem_ifWriteMem(we),
        .Address_out(addr), .Data_out(wdata), .Data_in(din0), .MIO_ready(rdy0),
        .switches(sw), .leds(leds0), .bus_error(err0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Full handshake; inputs are scrambled right after capture to prove they are latched.
    task automatic xfer(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input int lat, input string tag);
        int n;
        we = w; addr = a; wdata = d;
        if (sel) cpu2 = 1'b1; else cpu0 = 1'b1;
        step();
        we = ~w; addr = 32'hDEAD_BEE0; wdata = ~d;
        n = 1;
        while (!(sel ? rdy2 : rdy0) && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        cpu0 = 1'b0; cpu2 = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst = 1'b0; cpu0 = 1'b0; cpu2 = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; sw = '0;
        step();
        step();
        chk("rst_rdy2", 32'(rdy2), 32'd0);
        chk("rst_din2", din2, 32'd0);
        chk("rst_leds2", 32'(leds2), 32'd0);
        chk("rst_err2", 32'(err2), 32'd0);
        chk("rst_rdy0", 32'(rdy0), 32'd0);
        chk("rst_din0", din0, 32'd0);
        rst = 1'b1;
        step();

        xfer(1, 1, 32'h0000_0010, 32'h1234_5678, 3, "ram_wr");
        xfer(1, 0, 32'h0000_0010, 32'h0, 3, "ram_rd");
        chk("ram_rd_data", din2, 32'h1234_5678);

        we = 1'b1; addr = 32'hE000_0000; wdata = 32'h0001_00A5; cpu2 = 1'b1;
        pulses = 0;
        repeat (10) begin
            step();
            if (rdy2) pulses++;
        end
        chk("hold_pulses", 32'(pulses), 32'd1);
        chk("hold_leds", 32'(leds2), 32'h0000_00A5);
        cpu2 = 1'b0;
        step();
        step();
        xfer(1, 0, 32'hE000_0000, 32'h0, 3, "led_rd");
        chk("led_rd_data", din2, 32'h0000_00A5);

        xfer(1, 0, 32'h8000_0000, 32'h0, 3, "unm_rd");
        chk("unm_rd_data", din2, 32'h0);
        chk("unm_err", 32'(err2), 32'd1);
        xfer(1, 1, 32'h0000_0004, 32'hA5A5_0004, 3, "w4");
        chk("err_sticky", 32'(err2), 32'd1);
        sw = 16'h1234;
        xfer(1, 0, 32'hF000_0000, 32'h0, 3, "sw_rd2");
        chk("sw_rd2_data", din2, 32'h0000_1234);

        we = 1'b1; addr = 32'h0000_0004; wdata = 32'h5555_5555; cpu2 = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("arst_rdy", 32'(rdy2), 32'd0);
        chk("arst_din", din2, 32'd0);
        chk("arst_leds", 32'(leds2), 32'd0);
        chk("arst_err", 32'(err2), 32'd0);
        step();
        chk("arst_rdy_hold", 32'(rdy2), 32'd0);
        cpu2 = 1'b0;
        rst = 1'b1;
        step();
        xfer(1, 0, 32'h0000_0004, 32'h0, 3, "w4_rd");
        chk("w4_unchanged", din2, 32'hA5A5_0004);

        sw = 16'hBEEF;
        xfer(0, 0, 32'hF000_0000, 32'h0, 1, "sw_rd0");
        chk("sw_rd0_data", din0, 32'h0000_BEEF);
        xfer(0, 1, 32'hF000_0000, 32'h0000_FFFF, 1, "sw_wr0");
        chk("sw_wr_noerr", 32'(err0), 32'd0);
        xfer(0, 1, 32'h0000_003C, 32'h0BAD_F00D, 1, "ram0_wr");
        xfer(0, 0, 32'h0000_003C, 32'h0, 1, "ram0_rd");
        chk("ram0_rd_data", din0, 32'h0BAD_F00D);

        xfer(0, 1, 32'hF000_0004, 32'hFFFF_FFFE, 1, "ctr_wr");
        step();
        xfer(0, 0, 32'hF000_0004, 32'h0, 1, "ctr_rd");
`ifdef MIO_COUNTER_EN
        chk("ctr_wrap", din0, 32'h0000_0001);
        chk("ctr_noerr", 32'(err0), 32'd0);
`else
        chk("ctr_unm_data", din0, 32'h0);
        chk("ctr_unm_err", 32'(err0), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
